// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One WIDTH+1-bit trial subtraction per clock, quotient bits produced MSB first.
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_r;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;

    // Handshake: start is taken only when busy=0 (IDLE or DONE) and flush=0;
    // done pulses for exactly one cycle while result holds the new value.
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] res_fin;
    logic             last;
    logic             accept;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[WIDTH-1];
    assign b_neg     = is_signed & divisor[WIDTH-1];
    assign abs_a     = a_neg ? (~dividend + 1'b1) : dividend;
    assign abs_b     = b_neg ? (~divisor + 1'b1) : divisor;

    // The dividend register doubles as the quotient shift register: the
    // top bit feeds the remainder while the new quotient bit enters at bit 0.
    assign rem_sh  = {rem, dvd[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, dvs};
    assign qbit    = ~trial[WIDTH];
    assign rem_nx  = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx  = {dvd[WIDTH-2:0], qbit};
    assign res_fin = op_r[1] ? (neg_r ? (~rem_nx + 1'b1) : rem_nx)
                             : (neg_q ? (~quo_nx + 1'b1) : quo_nx);

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign accept = start && !flush && (state != CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op_r   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                    if (accept) begin
                        op_r  <= op;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dvd   <= abs_a;
                        dvs   <= abs_b;
                        rem   <= '0;
                        cnt   <= '0;
                        if (divisor == '0) begin
                            // Divide by zero bypasses the iteration entirely.
                            result <= op[1] ? dividend : '1;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    dvd <= quo_nx;
                    if (last) begin
                        cnt    <= '0;
                        result <= res_fin;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed vectors feed an expected-result queue,
// a negedge monitor pops and compares result and completion cycle on done.
module tb_iter_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W-1:0] last_res = '0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    iter_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with result 0x%08h, expected no done (cycle %0d)", result, cyc);
            end else begin
                logic [W-1:0] e;
                int ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("result", result, e);
                check("done_cycle", W'(cyc), W'(ec));
                check("busy_at_done", {31'd0, busy}, '0);
            end
        end
    end

    // driver: call at a negedge; returns at the negedge following the accept edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, input bit push);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            exp_cyc_q.push_back(cyc + 1 + ((b == '0) ? 0 : W));
        end
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0001;
    endtask

    // bounded wait for done; busy must stay high until then
    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 60) begin
            check("busy_in_calc", {31'd0, busy}, 32'd1);
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done after %0d cycles, expected done", k);
        end
    endtask

    typedef struct {
        logic [1:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[5]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[6]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{2'b01, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF};
        vecs[8]  = '{2'b11, 32'h0000_1234,  32'd0,          32'h0000_1234};
        vecs[9]  = '{2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
        vecs[10] = '{2'b00, 32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA};
        vecs[11] = '{2'b10, 32'd20,         32'hFFFF_FFFD,  32'd2};

        // reset state
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, '0);
        check("reset_done", {31'd0, done}, '0);
        check("reset_result", result, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed vectors, each from IDLE
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
            wait_done();
            last_res = vecs[i].e;
            @(negedge clk);
            check("idle_after_done", {30'd0, busy, done}, '0);
        end

        // flush mid-calculation: no done, result held
        issue(2'b01, 32'd1000, 32'd3, '0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, '0);
        check("flush_done", {31'd0, done}, '0);
        check("flush_result", result, last_res);

        // flush beats a simultaneous start
        op = 2'b01; dividend = 32'd9; divisor = 32'd3;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_wins_busy", {31'd0, busy}, '0);
        repeat (40) @(negedge clk);
        check("flush_result_held", result, last_res);

        issue(2'b01, 32'd9, 32'd3, 32'd3, 1'b1);
        wait_done();
        @(negedge clk);

        // back-to-back, with a stray start mid-calc
        issue(2'b01, 32'd50, 32'd5, 32'd10, 1'b1);
        repeat (5) @(negedge clk);
        op = 2'b11; dividend = 32'd77; divisor = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_busy", {31'd0, busy}, 32'd1);
        wait_done();
        issue(2'b11, 32'd50, 32'd7, 32'd1, 1'b1);
        wait_done();
        last_res = 32'd1;
        @(negedge clk);

        // reset mid-calculation
        issue(2'b01, 32'd50, 32'd5, '0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", {31'd0, busy}, '0);
        check("midreset_done", {31'd0, done}, '0);
        check("midreset_result", result, '0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        check("queue_empty", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
